aer_event_encoder: RTL and testbench
====================================

# aer_event_encoder

Downstream stage of the 4x4 pixel arbiter (`pixel_level_0`). It captures each granted pixel as an address-event word stamped with a free-running timestamp and stores it in an internal first-word-fall-through FIFO. It returns a one-cycle clear pulse to the granted pixel and throttles the arbiter through its enable input while the FIFO is full.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_W`, 16: timestamp width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (despite the name).
- `req_i`  in  1  arbiter "any pixel set" flag; status only.
- `gnt_i`  in  [3:0][3:0]  arbiter grant matrix; one-hot or zero.
- `x_add_i`  in  2  granted row index.
- `y_add_i`  in  2  granted column index.
- `enable_o`  out  1  drives arbiter `enable`; high when FIFO not full.
- `clr_o`  out  [3:0][3:0]  one-cycle clear pulse to the granted pixel's set latch.
- `ev_valid_o`  out  1  FIFO head valid.
- `ev_ready_i`  in  1  consumer accepts head.
- `ev_data_o`  out  TS_W+4  head word {ts, x[1:0], y[1:0]}.
- `fill_o`  out  $clog2(DEPTH+1)  current entry count.
- `err_o`  out  1  sticky protocol error.

## Operation
- Timestamp `ts`: increments every cycle; wraps from 2^TS_W−1 to 0; cleared by reset.
- FSM states: IDLE, CLEAR, HOLD.
  - IDLE to CLEAR: taken when `gnt_i != 0`, `gnt_i` is one-hot, `gnt_i[x_add_i][y_add_i] == 1`, and FIFO not full.
    - Same cycle: push {ts, x_add_i, y_add_i}.
    - Latch the address into `cap_x`/`cap_y`.
  - IDLE with grant present but FIFO full: stay in IDLE, no push, no error.
  - IDLE with `gnt_i` multi-hot, or the grant bit not at (x_add_i, y_add_i):
    - no push, set `err_o`, stay in IDLE.
  - CLEAR: `clr_o[cap_x][cap_y] = 1` for exactly this cycle; then HOLD.
  - HOLD: wait until `gnt_i[cap_x][cap_y] == 0`, then IDLE. The same pixel cannot be captured twice without its grant dropping.
- FIFO:
  - First-word fall-through: `ev_valid_o = (fill != 0)`, `ev_data_o` = head entry.
  - Pop when `ev_valid_o && ev_ready_i`.
  - Push and pop in the same cycle: fill unchanged; pointers wrap modulo DEPTH.
  - Full check for a push uses the fill at the start of the cycle; a same-cycle pop does not free space for that push.
  - Pop when empty is ignored.
- `enable_o = (fill_o != DEPTH)`, combinational from the fill register.
- `err_o` is cleared only by reset.
- Reset, mid-operation or otherwise:
  - state IDLE; ts = 0; pointers and fill = 0; `err_o` = 0.
  - `clr_o` = 0; `ev_valid_o` = 0; `enable_o` = 1.
  - Any FIFO contents are discarded; a pending clear pulse is not issued.

## Timing
- Capture in cycle N: the word holds the `ts` value of cycle N.
  - `ev_valid_o` and `fill_o` update from N+1.
  - `clr_o` pulse in N+1; HOLD from N+2.
- Minimum spacing between captures is 3 cycles (IDLE, CLEAR, HOLD with grant already low).
- `enable_o` falls in the cycle after the push that fills the FIFO, and rises in the cycle after the first pop from full.
- No combinational path from `ev_ready_i` to `enable_o` or `clr_o`.

## Test plan
- Reset then idle 5 cycles → all outputs 0 except `enable_o = 1`; `ts` = 5 at cycle 5.
- `gnt_i[2][1] = 1`, x = 2, y = 1 in cycle 10, grant dropped in cycle 12, `ev_ready_i` = 0 → `ev_data_o = {16'd10, 2'd2, 2'd1}` from cycle 11; `clr_o[2][1]` high only in cycle 11; `fill_o` = 1.
- `ev_ready_i` = 0, eight distinct grants → `fill_o` = 8 and `enable_o` = 0. A ninth grant is held with no push. One pop → `enable_o` = 1 next cycle; the ninth event is captured afterwards and FIFO order is preserved.
- Grant held high 6 cycles on pixel (3,3) → exactly one event and one `clr_o` pulse; the FSM stays in HOLD until the grant drops.
- `gnt_i` with bits [0][0] and [1][1] set → no push, `err_o` = 1 and sticky; a mismatched x/y with a one-hot grant also sets `err_o`.
- `TS_W` = 4, capture at ts = 15 and the next at ts = 2 → words carry 15 then 2 (wrap). Reset asserted while fill = 3 and in CLEAR → fill 0, no `clr_o` pulse.

Source files
------------

// File: rtl/aer_event_encoder.sv
// Address-event encoder: turns each arbiter grant into a timestamped {ts, x, y} word,
// buffers it in a first-word-fall-through FIFO and pulses a clear back to the pixel.
module aer_event_encoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic [3:0][3:0]            gnt_i,
  input  logic [1:0]                 x_add_i,
  input  logic [1:0]                 y_add_i,
  output logic                       enable_o,
  output logic [3:0][3:0]            clr_o,
  output logic                       ev_valid_o,
  input  logic                       ev_ready_i,
  output logic [TS_W+3:0]            ev_data_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o,
  output logic                       err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned DW = TS_W + 4;

  typedef enum logic [1:0] {StIdle, StClear, StHold} state_e;

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q;
  logic [1:0]      cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]   fill_q;
  logic [15:0]     gnt_flat;
  logic            push, pop, full, gnt_any, gnt_onehot, gnt_hit;
  logic            unused_req;

  // req_i is status only; the grant matrix carries everything needed.
  assign unused_req = req_i;

  assign gnt_flat   = gnt_i;
  assign gnt_any    = |gnt_flat;
  assign gnt_onehot = gnt_any && ((gnt_flat & (gnt_flat - 16'd1)) == 16'd0);
  assign gnt_hit    = gnt_i[x_add_i][y_add_i];

  // Full uses the fill at the start of the cycle, so a same-cycle pop never frees space.
  assign full = (fill_q == FW'(DEPTH));
  assign pop  = (fill_q != '0) && ev_ready_i;

  always_comb begin
    state_d = state_q;
    cap_x_d = cap_x_q;
    cap_y_d = cap_y_q;
    err_d   = err_q;
    push    = 1'b0;
    clr_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          if (gnt_onehot && gnt_hit) begin
            if (!full) begin
              push    = 1'b1;
              state_d = StClear;
              cap_x_d = x_add_i;
              cap_y_d = y_add_i;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StClear: begin
        clr_o[cap_x_q][cap_y_q] = 1'b1;
        state_d                 = StHold;
      end
      StHold: begin
        if (!gnt_i[cap_x_q][cap_y_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // rst_n is an active-high asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= StIdle;
      ts_q     <= '0;
      cap_x_q  <= '0;
      cap_y_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      cap_x_q <= cap_x_d;
      cap_y_q <= cap_y_d;
      err_q   <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q  <= fill_q + FW'(push) - FW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, x_add_i, y_add_i};
  end

  assign enable_o   = !full;
  assign ev_valid_o = (fill_q != '0);
  assign ev_data_o  = mem_q[rd_ptr_q];
  assign fill_o     = fill_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Bench for aer_event_encoder: directed scenarios plus a randomized run against a
// queue-based event model; a second instance with a 4-bit timestamp covers wrap-around.
module tb_aer_event_encoder;

  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req = 1'b0;
  logic [3:0][3:0] gnt = '0;
  logic [1:0]      x_add = '0;
  logic [1:0]      y_add = '0;
  logic            ev_ready = 1'b0;

  logic            enable, ev_valid, err;
  logic [3:0][3:0] clr;
  logic [19:0]     ev_data;
  logic [3:0]      fill;
  logic            enable4, ev_valid4, err4;
  logic [3:0][3:0] clr4;
  logic [7:0]      ev_data4;
  logic [3:0]      fill4;

  aer_event_encoder #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst), .req_i(req), .gnt_i(gnt), .x_add_i(x_add), .y_add_i(y_add),
    .enable_o(enable), .clr_o(clr), .ev_valid_o(ev_valid), .ev_ready_i(ev_ready),
    .ev_data_o(ev_data), .fill_o(fill), .err_o(err)
  );

  aer_event_encoder #(.DEPTH(DEPTH), .TS_W(4)) dut4 (
    .clk(clk), .rst_n(rst), .req_i(req), .gnt_i(gnt), .x_add_i(x_add), .y_add_i(y_add),
    .enable_o(enable4), .clr_o(clr4), .ev_valid_o(ev_valid4), .ev_ready_i(ev_ready),
    .ev_data_o(ev_data4), .fill_o(fill4), .err_o(err4)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the expected timestamp of the current cycle.
  logic [31:0] cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Event-level model: expected FIFO contents, sticky error, and capture availability.
  logic [19:0]     exp_q[$];
  logic [7:0]      exp4_q[$];
  bit              m_err, m_clr_due, m_wait;
  int              m_px, m_py;
  logic [3:0][3:0] m_clr;

  function automatic logic [15:0] px(input int x, input int y);
    logic [3:0][3:0] m;
    m = '0;
    m[x][y] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, land on the next negedge.
  task automatic step(input logic [15:0] g, input logic [1:0] x, input logic [1:0] y,
                      input logic rdy);
    logic [3:0][3:0] gm;
    bit full, do_pop, do_push;
    gnt = g; x_add = x; y_add = y; ev_ready = rdy; req = |g;
    gm = g;
    full    = (exp_q.size() == DEPTH);
    do_pop  = (exp_q.size() != 0) && rdy;
    do_push = 1'b0;
    if (m_clr_due) begin
      // This is the clear cycle of the previous capture; no capture possible.
      m_clr_due = 1'b0;
      m_wait    = 1'b1;
    end else if (m_wait) begin
      if (!gm[m_px][m_py]) m_wait = 1'b0;
    end else if (g != 16'd0) begin
      if ($countones(g) == 1 && gm[x][y]) begin
        if (!full) begin
          do_push = 1'b1; m_clr_due = 1'b1; m_px = x; m_py = y;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    m_clr = '0;
    if (m_clr_due) m_clr[m_px][m_py] = 1'b1;
    if (do_pop) begin
      void'(exp_q.pop_front());
      void'(exp4_q.pop_front());
    end
    if (do_push) begin
      exp_q.push_back({cyc[15:0], x, y});
      exp4_q.push_back({cyc[3:0], x, y});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = '0; x_add = '0; y_add = '0; ev_ready = 1'b0; req = 1'b0;
    exp_q.delete(); exp4_q.delete();
    m_err = 0; m_clr_due = 0; m_wait = 0; m_clr = '0; m_px = 0; m_py = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({enable, ev_valid, fill, err} !== {1'b1, 1'b0, 4'd0, 1'b0} || clr !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got en=%b v=%b fill=%0d err=%b clr=%h want 1 0 0 0 0000",
                 i, enable, ev_valid, fill, err, clr);
      end
      step(16'd0, 2'd0, 2'd0, 1'b0);
    end
    step(px(0, 0), 2'd0, 2'd0, 1'b0);
    n_chk++;
    if (ev_data !== 20'h00050 || ev_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ts5: got data=%h v=%b want 00050 1", ev_data, ev_valid);
    end
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b1);
    n_chk++;
    if (ev_valid !== 1'b0 || fill !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_drain: got v=%b fill=%0d want 0 0", ev_valid, fill);
    end
  endtask

  task automatic test_single();
    do_reset();
    repeat (10) step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(2, 1), 2'd2, 2'd1, 1'b0);
    n_chk++;
    if (ev_data !== 20'h000A9 || fill !== 4'd1 || clr !== px(2, 1)) begin
      n_fail++;
      $display("FAIL single_capture: got data=%h fill=%0d clr=%h want 000a9 1 %h",
               ev_data, fill, clr, px(2, 1));
    end
    step(px(2, 1), 2'd2, 2'd1, 1'b0);
    n_chk++;
    if (clr !== 16'd0 || fill !== 4'd1) begin
      n_fail++;
      $display("FAIL single_clr_once: got clr=%h fill=%0d want 0000 1", clr, fill);
    end
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b0);
    n_chk++;
    if (ev_data !== 20'h000A9 || fill !== 4'd1) begin
      n_fail++;
      $display("FAIL single_hold: got data=%h fill=%0d want 000a9 1", ev_data, fill);
    end
    step(16'd0, 2'd0, 2'd0, 1'b1);
  endtask

  task automatic test_full();
    int drained;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(px(k % 4, k / 4), 2'(k % 4), 2'(k / 4), 1'b0);
      step(16'd0, 2'd0, 2'd0, 1'b0);
      step(16'd0, 2'd0, 2'd0, 1'b0);
    end
    n_chk++;
    if (fill !== 4'd8 || enable !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: got fill=%0d en=%b want 8 0", fill, enable);
    end
    repeat (3) step(px(3, 3), 2'd3, 2'd3, 1'b0);
    n_chk++;
    if (fill !== 4'd8 || enable !== 1'b0 || clr !== 16'd0) begin
      n_fail++;
      $display("FAIL full_held: got fill=%0d en=%b clr=%h want 8 0 0000", fill, enable, clr);
    end
    step(px(3, 3), 2'd3, 2'd3, 1'b1);
    n_chk++;
    if (fill !== 4'd7 || enable !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: got fill=%0d en=%b want 7 1", fill, enable);
    end
    step(px(3, 3), 2'd3, 2'd3, 1'b0);
    n_chk++;
    if (fill !== 4'd8 || enable !== 1'b0 || clr !== px(3, 3)) begin
      n_fail++;
      $display("FAIL full_ninth: got fill=%0d en=%b clr=%h want 8 0 %h", fill, enable, clr,
               px(3, 3));
    end
    drained = 0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      n_chk++;
      if (ev_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL full_order #%0d: got %h want %h", k, ev_data, exp_q[0]);
      end
      step(16'd0, 2'd0, 2'd0, 1'b1);
      drained++;
    end
    n_chk++;
    if (drained != 8 || ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d pops v=%b want 8 0", drained, ev_valid);
    end
  endtask

  task automatic test_hold();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(px(3, 3), 2'd3, 2'd3, 1'b0);
      if (clr === px(3, 3)) pulses++;
    end
    n_chk++;
    if (pulses != 1 || fill !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_single: got pulses=%0d fill=%0d want 1 1", pulses, fill);
    end
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(3, 3), 2'd3, 2'd3, 1'b0);
    n_chk++;
    if (fill !== 4'd2 || clr !== px(3, 3)) begin
      n_fail++;
      $display("FAIL hold_recapture: got fill=%0d clr=%h want 2 %h", fill, clr, px(3, 3));
    end
    repeat (4) step(16'd0, 2'd0, 2'd0, 1'b1);
  endtask

  task automatic test_error();
    do_reset();
    step(px(0, 0) | px(1, 1), 2'd0, 2'd0, 1'b0);
    n_chk++;
    if (err !== 1'b1 || fill !== 4'd0) begin
      n_fail++;
      $display("FAIL err_multihot: got err=%b fill=%0d want 1 0", err, fill);
    end
    repeat (3) step(16'd0, 2'd0, 2'd0, 1'b0);
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    do_reset();
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: got %b want 0", err);
    end
    step(px(1, 2), 2'd2, 2'd1, 1'b0);
    n_chk++;
    if (err !== 1'b1 || fill !== 4'd0) begin
      n_fail++;
      $display("FAIL err_mismatch: got err=%b fill=%0d want 1 0", err, fill);
    end
    step(px(1, 2), 2'd1, 2'd2, 1'b0);
    n_chk++;
    if (err !== 1'b1 || fill !== 4'd1) begin
      n_fail++;
      $display("FAIL err_then_capture: got err=%b fill=%0d want 1 1", err, fill);
    end
    repeat (3) step(16'd0, 2'd0, 2'd0, 1'b1);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    repeat (15) step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(1, 0), 2'd1, 2'd0, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(2, 3), 2'd2, 2'd3, 1'b0);
    n_chk++;
    if (ev_data4 !== 8'hF4 || ev_data !== 20'h000F4) begin
      n_fail++;
      $display("FAIL wrap_first: got %h/%h want f4/000f4", ev_data4, ev_data);
    end
    step(16'd0, 2'd0, 2'd0, 1'b1);
    n_chk++;
    if (ev_data4 !== 8'h2B || ev_data !== 20'h0012B || ev_data4 !== exp4_q[0]) begin
      n_fail++;
      $display("FAIL wrap_second: got %h/%h want 2b/0012b", ev_data4, ev_data);
    end
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(0, 1), 2'd0, 2'd1, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(16'd0, 2'd0, 2'd0, 1'b0);
    step(px(0, 2), 2'd0, 2'd2, 1'b0);
    n_chk++;
    if (fill !== 4'd3 || clr !== px(0, 2)) begin
      n_fail++;
      $display("FAIL rst_setup: got fill=%0d clr=%h want 3 %h", fill, clr, px(0, 2));
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (fill !== 4'd0 || clr !== 16'd0 || ev_valid !== 1'b0 || enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got fill=%0d clr=%h v=%b en=%b want 0 0000 0 1",
               fill, clr, ev_valid, enable);
    end
    do_reset();
    step(16'd0, 2'd0, 2'd0, 1'b0);
    n_chk++;
    if (clr !== 16'd0 || fill !== 4'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: got clr=%h fill=%0d err=%b want 0000 0 0", clr, fill, err);
    end
  endtask

  task automatic test_random();
    logic [15:0] g;
    logic [1:0]  x, y;
    int          kind, hold;
    logic        rdy;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 19);
      x = 2'($urandom_range(0, 3));
      y = 2'($urandom_range(0, 3));
      if (kind < 3)       g = 16'd0;
      else if (kind < 17) g = px(x, y);
      else if (kind == 17) begin
        g = px(x, y);
        x = 2'($urandom_range(0, 3));
      end else g = px(x, y) | px($urandom_range(0, 3), $urandom_range(0, 3));
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        rdy = ($urandom_range(0, 2) == 0);
        step(g, x, y, rdy);
        n_chk++;
        if (fill !== 4'(exp_q.size()) || ev_valid !== (exp_q.size() != 0) ||
            enable !== (exp_q.size() != DEPTH) || clr !== m_clr || err !== m_err) begin
          n_fail++;
          $display("FAIL rand_ctrl cyc%0d: got fill=%0d v=%b en=%b clr=%h err=%b want %0d %b %b %h %b",
                   cyc, fill, ev_valid, enable, clr, err, exp_q.size(), exp_q.size() != 0,
                   exp_q.size() != DEPTH, m_clr, m_err);
        end
        if (exp_q.size() != 0) begin
          n_chk++;
          if (ev_data !== exp_q[0] || ev_data4 !== exp4_q[0]) begin
            n_fail++;
            $display("FAIL rand_data cyc%0d: got %h/%h want %h/%h", cyc, ev_data, ev_data4,
                     exp_q[0], exp4_q[0]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_hold();
    test_error();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
